// File: rtl/icache_fill_ctrl_if.sv
// Bundle of fetch, cache-array and memory signals around the icache fill controller.
// master: the controller; slave: the environment (fetch stage, cache array, memory).
interface icache_fill_ctrl_if #(
  parameter int ADDR_BITS = 16,
  parameter int SET_BITS  = 3,
  parameter int TAG_BITS  = ADDR_BITS - SET_BITS - 3
);
  logic                 proc_req;
  logic [ADDR_BITS-1:0] proc_addr;
  logic                 proc_valid;
  logic [63:0]          proc_data;
  logic                 cache_rd_hit;
  logic [63:0]          cache_rd_data;
  logic [SET_BITS-1:0]  cache_rd_idx;
  logic [TAG_BITS-1:0]  cache_rd_tag;
  logic                 cache_wr_en;
  logic [SET_BITS-1:0]  cache_wr_idx;
  logic [TAG_BITS-1:0]  cache_wr_tag;
  logic [63:0]          cache_wr_data;
  logic [1:0]           mem_command;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [3:0]           mem_response;
  logic [3:0]           mem_tag;
  logic [63:0]          mem_data;
  logic                 busy;

  modport master (
    input  proc_req, proc_addr, cache_rd_hit, cache_rd_data,
           mem_response, mem_tag, mem_data,
    output proc_valid, proc_data, cache_rd_idx, cache_rd_tag,
           cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
           mem_command, mem_addr, busy
  );

  modport slave (
    output proc_req, proc_addr, cache_rd_hit, cache_rd_data,
           mem_response, mem_tag, mem_data,
    input  proc_valid, proc_data, cache_rd_idx, cache_rd_tag,
           cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
           mem_command, mem_addr, busy
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Blocking instruction-cache miss controller with a single outstanding miss.
// Hits are returned combinationally in IDLE; a miss issues LOAD until accepted,
// then waits for the tagged response, fills the cache and forwards the block.
module icache_fill_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int SET_BITS  = 3,
  parameter int TAG_BITS  = ADDR_BITS - SET_BITS - 3
) (
  input  logic              clock,
  input  logic              reset,
  icache_fill_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  logic [1:0]           r_state;
  logic [ADDR_BITS-1:0] r_miss_addr;
  logic [3:0]           r_pend_tag;

  logic [1:0]           w_state_nxt;
  logic [ADDR_BITS-1:0] w_miss_addr_nxt;
  logic [3:0]           w_pend_tag_nxt;
  logic                 w_fill;
  logic                 w_same_block;
  logic                 w_unused;

  // Byte offset within the block never affects lookup or fill.
  assign w_unused = ^bus.proc_addr[2:0];

  // Output decode and next-state selection; the fill has priority over any new lookup.
  always_comb begin
    w_fill       = (r_pend_tag != 4'd0) && (bus.mem_tag == r_pend_tag);
    w_same_block = (bus.proc_addr[ADDR_BITS-1:3] == r_miss_addr[ADDR_BITS-1:3]);

    bus.cache_rd_idx  = bus.proc_addr[SET_BITS+2:3];
    bus.cache_rd_tag  = bus.proc_addr[ADDR_BITS-1:SET_BITS+3];
    bus.proc_valid    = 1'b0;
    bus.proc_data     = 64'd0;
    bus.cache_wr_en   = 1'b0;
    bus.cache_wr_idx  = '0;
    bus.cache_wr_tag  = '0;
    bus.cache_wr_data = 64'd0;
    bus.mem_command   = CMD_NONE;
    bus.mem_addr      = '0;
    bus.busy          = (r_state != ST_IDLE);

    w_state_nxt     = r_state;
    w_miss_addr_nxt = r_miss_addr;
    w_pend_tag_nxt  = r_pend_tag;

    case (r_state)
      ST_IDLE: begin
        if (bus.proc_req && bus.cache_rd_hit) begin
          bus.proc_valid = 1'b1;
          bus.proc_data  = bus.cache_rd_data;
        end else if (bus.proc_req) begin
          w_miss_addr_nxt = {bus.proc_addr[ADDR_BITS-1:3], 3'b000};
          w_state_nxt     = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        bus.mem_command = CMD_LOAD;
        bus.mem_addr    = r_miss_addr;
        if (bus.mem_response != 4'd0) begin
          w_pend_tag_nxt = bus.mem_response;
          w_state_nxt    = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (w_fill) begin
          bus.cache_wr_en   = 1'b1;
          bus.cache_wr_idx  = r_miss_addr[SET_BITS+2:3];
          bus.cache_wr_tag  = r_miss_addr[ADDR_BITS-1:SET_BITS+3];
          bus.cache_wr_data = bus.mem_data;
          bus.proc_data     = bus.mem_data;
          bus.proc_valid    = bus.proc_req && w_same_block;
          w_pend_tag_nxt    = 4'd0;
          w_state_nxt       = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_pend_tag_nxt = 4'd0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State, latched miss address and pending transaction tag; reset drops any miss in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_miss_addr <= '0;
      r_pend_tag  <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_miss_addr <= w_miss_addr_nxt;
      r_pend_tag  <= w_pend_tag_nxt;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed vector table, hand-written redirect/reset
// sequences, then randomized traffic compared against a transaction-level model.
module tb_icache_fill_ctrl;

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        hit;
    logic [63:0] rdata;
    logic [3:0]  resp;
    logic [3:0]  mtag;
    logic [63:0] mdata;
  } in_t;

  typedef struct packed {
    logic        pv;
    logic [63:0] pdata;
    logic        wen;
    logic [2:0]  widx;
    logic [9:0]  wtag;
    logic [1:0]  cmd;
    logic [15:0] maddr;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Model of the controller: is a miss outstanding, for which block, under which accepted tag.
  logic        m_have_miss;
  logic [12:0] m_block;
  logic [3:0]  m_tag;

  icache_fill_ctrl_if #(.ADDR_BITS(16), .SET_BITS(3)) bus ();

  icache_fill_ctrl #(.ADDR_BITS(16), .SET_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t v(
    input logic rst, input logic req, input logic [15:0] addr, input logic hit,
    input logic [63:0] rdata, input logic [3:0] resp, input logic [3:0] mtag,
    input logic [63:0] mdata, input logic pv, input logic [63:0] pdata,
    input logic wen, input logic [2:0] widx, input logic [9:0] wtag,
    input logic [1:0] cmd, input logic [15:0] maddr, input logic busy);
    vec_t r;
    r.i = '{rst, req, addr, hit, rdata, resp, mtag, mdata};
    r.o = '{pv, pdata, wen, widx, wtag, cmd, maddr, busy};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs, then clock it.
  task automatic apply(input in_t vi, input out_t vo, input string nm);
    reset             = vi.rst;
    bus.proc_req      = vi.req;
    bus.proc_addr     = vi.addr;
    bus.cache_rd_hit  = vi.hit;
    bus.cache_rd_data = vi.rdata;
    bus.mem_response  = vi.resp;
    bus.mem_tag       = vi.mtag;
    bus.mem_data      = vi.mdata;
    #1;
    chk({nm, ".rd_idx"},  64'(bus.cache_rd_idx),  64'((vi.addr / 16'd8) % 16'd8));
    chk({nm, ".rd_tag"},  64'(bus.cache_rd_tag),  64'(vi.addr / 16'd64));
    chk({nm, ".busy"},    64'(bus.busy),          64'(vo.busy));
    chk({nm, ".cmd"},     64'(bus.mem_command),   64'(vo.cmd));
    chk({nm, ".pvalid"},  64'(bus.proc_valid),    64'(vo.pv));
    chk({nm, ".wr_en"},   64'(bus.cache_wr_en),   64'(vo.wen));
    if (vo.cmd == 2'd1) begin
      chk({nm, ".mem_addr"}, 64'(bus.mem_addr), 64'(vo.maddr));
    end
    if (vo.pv || vo.wen) begin
      chk({nm, ".pdata"}, bus.proc_data, vo.pdata);
    end
    if (vo.wen) begin
      chk({nm, ".wr_idx"},  64'(bus.cache_wr_idx), 64'(vo.widx));
      chk({nm, ".wr_tag"},  64'(bus.cache_wr_tag), 64'(vo.wtag));
      chk({nm, ".wr_data"}, bus.cache_wr_data,     vi.mdata);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic out_t model_out(input in_t vi);
    out_t o;
    o = '0;
    o.busy = m_have_miss;
    if (!m_have_miss) begin
      o.pv    = vi.req && vi.hit;
      o.pdata = vi.rdata;
    end else if (m_tag == 4'd0) begin
      o.cmd   = 2'd1;
      o.maddr = 16'(m_block) * 16'd8;
    end else if (vi.mtag == m_tag) begin
      o.wen   = 1'b1;
      o.widx  = 3'(m_block % 13'd8);
      o.wtag  = 10'(m_block / 13'd8);
      o.pdata = vi.mdata;
      o.pv    = vi.req && ((vi.addr / 16'd8) == 16'(m_block));
    end else begin
      o.pv = 1'b0;
    end
    return o;
  endfunction

  task automatic model_step(input in_t vi);
    if (vi.rst) begin
      m_have_miss = 1'b0;
      m_tag       = 4'd0;
    end else if (!m_have_miss) begin
      if (vi.req && !vi.hit) begin
        m_have_miss = 1'b1;
        m_block     = 13'(vi.addr / 16'd8);
      end
    end else if (m_tag == 4'd0) begin
      if (vi.resp != 4'd0) m_tag = vi.resp;
    end else if (vi.mtag == m_tag) begin
      m_have_miss = 1'b0;
      m_tag       = 4'd0;
    end
  endtask

  vec_t tbl [14];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            rst   req   addr       hit   rdata          resp  mtag  mdata            pv    pdata            wen   widx  wtag    cmd   maddr      busy
    tbl[0]  = v(1'b1, 1'b0, 16'h0000, 1'b0, 64'h0,         4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b0);
    tbl[1]  = v(1'b1, 1'b0, 16'h0128, 1'b0, 64'h0,         4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b0);
    tbl[2]  = v(1'b0, 1'b1, 16'h0128, 1'b1, 64'hDEAD,      4'd0, 4'd0, 64'h0,         1'b1, 64'hDEAD,      1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b0);
    tbl[3]  = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0,         4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b0);
    tbl[4]  = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0,         4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd1, 16'h0130, 1'b1);
    tbl[5]  = v(1'b0, 1'b1, 16'h0134, 1'b1, 64'h5555,      4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd1, 16'h0130, 1'b1);
    tbl[6]  = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0,         4'd3, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd1, 16'h0130, 1'b1);
    tbl[7]  = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0,         4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b1);
    tbl[8]  = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0,         4'd0, 4'd2, 64'h1111,      1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b1);
    tbl[9]  = v(1'b0, 1'b1, 16'h0134, 1'b1, 64'h7777,      4'd7, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b1);
    tbl[10] = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0,         4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b1);
    tbl[11] = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0,         4'd0, 4'd3, 64'hBEEF,      1'b1, 64'hBEEF,      1'b1, 3'd6, 10'h004, 2'd0, 16'h0000, 1'b1);
    tbl[12] = v(1'b0, 1'b0, 16'h0134, 1'b0, 64'h0,         4'd5, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b0);
    tbl[13] = v(1'b0, 1'b0, 16'h0134, 1'b0, 64'h0,         4'd0, 4'd0, 64'h0,         1'b0, 64'h0,         1'b0, 3'd0, 10'h0,  2'd0, 16'h0000, 1'b0);

    // Hold reset through one edge so the first checked cycle sees a defined state.
    reset             = 1'b1;
    bus.proc_req      = 1'b0;
    bus.proc_addr     = 16'h0000;
    bus.cache_rd_hit  = 1'b0;
    bus.cache_rd_data = 64'h0;
    bus.mem_response  = 4'd0;
    bus.mem_tag       = 4'd0;
    bus.mem_data      = 64'h0;
    @(posedge clock);
    @(negedge clock);

    for (int k = 0; k < 14; k++) begin
      apply(tbl[k].i, tbl[k].o, $sformatf("tbl%0d", k));
    end

    // Redirect while waiting: fill of block 0x0130 completes without proc_valid, then 0x0200 hits.
    begin
      vec_t s;
      s = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0,    1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd0, 16'h0000, 1'b0); apply(s.i, s.o, "redir_miss");
      s = v(1'b0, 1'b1, 16'h0134, 1'b0, 64'h0, 4'd3, 4'd0, 64'h0,    1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd1, 16'h0130, 1'b1); apply(s.i, s.o, "redir_req");
      s = v(1'b0, 1'b1, 16'h0200, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0,    1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd0, 16'h0000, 1'b1); apply(s.i, s.o, "redir_wait");
      s = v(1'b0, 1'b1, 16'h0200, 1'b1, 64'h42, 4'd0, 4'd3, 64'hCAFE, 1'b0, 64'hCAFE, 1'b1, 3'd6, 10'h004, 2'd0, 16'h0000, 1'b1); apply(s.i, s.o, "redir_fill");
      s = v(1'b0, 1'b1, 16'h0200, 1'b1, 64'h1234, 4'd0, 4'd0, 64'h0, 1'b1, 64'h1234, 1'b0, 3'd0, 10'h0,   2'd0, 16'h0000, 1'b0); apply(s.i, s.o, "redir_hit");

      // Reset while waiting on tag 5: the late tag must not fill.
      s = v(1'b0, 1'b1, 16'h0040, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0,    1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd0, 16'h0000, 1'b0); apply(s.i, s.o, "rst_miss");
      s = v(1'b0, 1'b1, 16'h0040, 1'b0, 64'h0, 4'd5, 4'd0, 64'h0,    1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd1, 16'h0040, 1'b1); apply(s.i, s.o, "rst_req");
      s = v(1'b1, 1'b0, 16'h0040, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0,    1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd0, 16'h0000, 1'b1); apply(s.i, s.o, "rst_assert");
      s = v(1'b0, 1'b0, 16'h0040, 1'b0, 64'h0, 4'd0, 4'd5, 64'h9999, 1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd0, 16'h0000, 1'b0); apply(s.i, s.o, "rst_late_tag");
      s = v(1'b0, 1'b0, 16'h0040, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0,    1'b0, 64'h0,    1'b0, 3'd0, 10'h0,   2'd0, 16'h0000, 1'b0); apply(s.i, s.o, "rst_idle");
    end

    // Randomized traffic against the model, starting from IDLE.
    m_have_miss = 1'b0;
    m_block     = 13'd0;
    m_tag       = 4'd0;
    begin
      in_t  ri;
      out_t ro;
      logic [15:0] cur_addr;
      cur_addr = 16'($urandom_range(0, 65535));
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 9) == 0) cur_addr = 16'($urandom_range(0, 65535));
        ri.rst   = ($urandom_range(0, 99) == 0);
        ri.req   = ($urandom_range(0, 3) != 0);
        ri.addr  = cur_addr;
        ri.hit   = 1'($urandom_range(0, 1));
        ri.rdata = {$urandom, $urandom};
        ri.resp  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        if (m_tag != 4'd0 && $urandom_range(0, 3) == 0) ri.mtag = m_tag;
        else ri.mtag = 4'($urandom_range(0, 15));
        ri.mdata = {$urandom, $urandom};
        ro = model_out(ri);
        apply(ri, ro, $sformatf("rnd%0d", n));
        model_step(ri);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
